// File: rtl/mtr_duty_ctrl.sv
// Motor duty controller: signed speed command -> slew-limited PWM duty plus direction outputs with dead time.
// Build option: define MTR_DUTY_SLEW_EN to ramp duty by SLEW_STEP per PWM period; otherwise duty jumps.
module mtr_duty_ctrl #(
  parameter logic [10:0] MIN_DUTY   = 11'd64,
  parameter logic [10:0] SLEW_STEP  = 11'd32,
  parameter int          DEAD_TICKS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] spd,
  input  logic        spd_vld,
  output logic [10:0] duty,
  output logic        fwd,
  output logic        rev,
  output logic        busy
);

  typedef enum logic [1:0] {STOP, FWD, REV, DEAD} state_t;

`ifdef MTR_DUTY_SLEW_EN
  localparam logic [10:0] STEP_EFF = SLEW_STEP;
`else
  // A full-scale step lets every move complete within a single period.
  localparam logic [10:0] STEP_EFF = SLEW_STEP | 11'h7FF;
`endif
  localparam logic [7:0] DEAD_LAST = 8'(DEAD_TICKS - 1);

  state_t      state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic [11:0] tgt_q, tgt_d;
  logic [10:0] duty_q, duty_d;
  logic        fwd_q, fwd_d;
  logic        rev_q, rev_d;
  logic [7:0]  dead_q, dead_d;

  logic        tick;
  logic        tgt_zero, tgt_pos, tgt_neg, same_dir;
  logic [11:0] tgt_mag;
  logic [12:0] tgt_sum;
  logic [10:0] tgt_duty;

  function automatic logic [10:0] step_toward(input logic [10:0] cur, input logic [10:0] dst);
    logic [10:0] diff;
    if (dst >= cur) begin
      diff = dst - cur;
      step_toward = (diff > STEP_EFF) ? cur + STEP_EFF : dst;
    end else begin
      diff = cur - dst;
      step_toward = (diff > STEP_EFF) ? cur - STEP_EFF : dst;
    end
  endfunction

  assign tick     = (cnt_q == 11'h7FF);
  assign tgt_zero = (tgt_q == 12'd0);
  assign tgt_neg  = tgt_q[11];
  assign tgt_pos  = !tgt_neg && !tgt_zero;
  assign same_dir = (state_q == FWD && tgt_pos) || (state_q == REV && tgt_neg);

  // -2048 has no positive twin in 12 bits, so it is pinned to 2047.
  assign tgt_mag  = (tgt_q == 12'h800) ? 12'd2047 : (tgt_neg ? 12'd0 - tgt_q : tgt_q);
  assign tgt_sum  = {1'b0, tgt_mag} + {2'b00, MIN_DUTY};
  assign tgt_duty = tgt_zero ? 11'd0 : ((tgt_sum > 13'd2047) ? 11'h7FF : tgt_sum[10:0]);

  always_comb begin
    cnt_d   = cnt_q + 11'd1;
    tgt_d   = spd_vld ? spd : tgt_q;
    state_d = state_q;
    duty_d  = duty_q;
    dead_d  = dead_q;
    if (tick) begin
      unique case (state_q)
        STOP: begin
          if (tgt_pos) begin
            state_d = FWD;
            duty_d  = step_toward(11'd0, tgt_duty);
          end else if (tgt_neg) begin
            state_d = REV;
            duty_d  = step_toward(11'd0, tgt_duty);
          end
        end
        FWD, REV: begin
          if (same_dir) begin
            duty_d = step_toward(duty_q, tgt_duty);
          end else if (duty_q != 11'd0) begin
            duty_d = step_toward(duty_q, 11'd0);
          end else if (tgt_zero) begin
            state_d = STOP;
          end else begin
            state_d = DEAD;
            dead_d  = 8'd0;
          end
        end
        DEAD: begin
          if (dead_q == DEAD_LAST) begin
            dead_d = 8'd0;
            if (tgt_pos) begin
              state_d = FWD;
              duty_d  = step_toward(11'd0, tgt_duty);
            end else if (tgt_neg) begin
              state_d = REV;
              duty_d  = step_toward(11'd0, tgt_duty);
            end else begin
              state_d = STOP;
            end
          end else begin
            dead_d = dead_q + 8'd1;
          end
        end
      endcase
    end
    fwd_d = (state_d == FWD);
    rev_d = (state_d == REV);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= STOP;
      cnt_q   <= 11'd0;
      tgt_q   <= 12'd0;
      duty_q  <= 11'd0;
      fwd_q   <= 1'b0;
      rev_q   <= 1'b0;
      dead_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      duty_q  <= duty_d;
      fwd_q   <= fwd_d;
      rev_q   <= rev_d;
      dead_q  <= dead_d;
    end
  end

  // Busy also covers a pending direction change whose duty happens to match the new target.
  assign busy = (state_q == DEAD) || (duty_q != tgt_duty) ||
                ((state_q == FWD || state_q == REV) && !same_dir);
  assign duty = duty_q;
  assign fwd  = fwd_q;
  assign rev  = rev_q;

endmodule

// File: tb/tb_mtr_duty_ctrl.sv
// Directed testbench for mtr_duty_ctrl; expectations follow whether MTR_DUTY_SLEW_EN is defined.
module tb_mtr_duty_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] spd;
  logic        spdVld;
  logic [10:0] duty;
  logic        fwd;
  logic        rev;
  logic        busy;

  int errCount   = 0;
  int checkCount = 0;
  int phaseCnt   = 0;

  mtr_duty_ctrl dut (
    .clk    (clk),
    .rst    (rst),
    .spd    (spd),
    .spd_vld(spdVld),
    .duty   (duty),
    .fwd    (fwd),
    .rev    (rev),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  // Bench-side PWM period position, used to land just after each period start.
  always @(posedge clk) phaseCnt <= (rst || phaseCnt == 2047) ? 0 : phaseCnt + 1;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checkCount++;
    if (actual != expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [11:0] val);
    @(negedge clk);
    spd    = val;
    spdVld = 1'b1;
    @(negedge clk);
    spdVld = 1'b0;
  endtask

  task automatic waitTick();
    int guard = 0;
    do begin
      @(posedge clk);
      #1;
      guard++;
    end while (phaseCnt != 0 && guard < 2100);
    if (phaseCnt != 0) checkOutput("tickTimeout", phaseCnt, 0);
  endtask

  task automatic checkTick(input string tag, input int expDuty, input int expFwd, input int expRev);
    waitTick();
    checkOutput({tag, ".duty"}, duty, expDuty);
    checkOutput({tag, ".fwd"}, fwd, expFwd);
    checkOutput({tag, ".rev"}, rev, expRev);
    checkOutput({tag, ".excl"}, fwd & rev, 0);
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, ".duty"}, duty, 0);
    checkOutput({tag, ".fwd"}, fwd, 0);
    checkOutput({tag, ".rev"}, rev, 0);
    checkOutput({tag, ".busy"}, busy, 0);
  endtask

  task automatic pulseReset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst    = 1'b1;
    spd    = 12'd0;
    spdVld = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    checkIdle("reset");

`ifdef MTR_DUTY_SLEW_EN
    applyStimulus(12'd400);
    checkOutput("ramp.busyStart", busy, 1);
    for (int k = 1; k <= 14; k++) checkTick($sformatf("ramp%0d", k), 32 * k, 1, 0);
    checkTick("ramp15", 464, 1, 0);
    checkOutput("ramp.busyEnd", busy, 0);

    pulseReset();
    checkIdle("resetSteady");
    checkTick("afterReset", 0, 0, 0);

    applyStimulus(12'd1);
    checkTick("small1", 32, 1, 0);
    checkTick("small2", 64, 1, 0);
    checkTick("small3", 65, 1, 0);

    applyStimulus(-12'sd100);
    checkTick("down1", 33, 1, 0);
    checkTick("down2", 1, 1, 0);
    checkTick("down3", 0, 1, 0);
    checkTick("dead1", 0, 0, 0);
    checkOutput("dead1.busy", busy, 1);
    checkTick("dead2", 0, 0, 0);
    for (int k = 1; k <= 5; k++) checkTick($sformatf("revUp%0d", k), 32 * k, 0, 1);
    checkTick("revUp6", 164, 0, 1);
    checkOutput("revUp.busy", busy, 0);

    applyStimulus(12'd0);
    for (int k = 1; k <= 5; k++) checkTick($sformatf("revDown%0d", k), 164 - 32 * k, 0, 1);
    checkTick("revDown6", 0, 0, 1);
    checkTick("stop", 0, 0, 0);
    checkOutput("stop.busy", busy, 0);
`else
    applyStimulus(12'd400);
    checkOutput("jump.busyStart", busy, 1);
    checkTick("jump", 464, 1, 0);
    checkOutput("jump.busyEnd", busy, 0);

    applyStimulus(-12'sd400);
    checkTick("revZero", 0, 1, 0);
    checkOutput("revZero.busy", busy, 1);
    checkTick("dead1", 0, 0, 0);
    checkOutput("dead1.busy", busy, 1);
    checkTick("dead2", 0, 0, 0);
    checkTick("revOn", 464, 0, 1);
    checkOutput("revOn.busy", busy, 0);

    applyStimulus(12'h800);
    checkTick("satNeg", 2047, 0, 1);

    applyStimulus(12'd0);
    checkTick("stop1", 0, 0, 1);
    checkTick("stop2", 0, 0, 0);
    checkOutput("stop2.busy", busy, 0);

    // Command strobed on the period-end cycle itself: that edge still sees the old zero target.
    begin
      int guard = 0;
      do begin
        @(posedge clk);
        #1;
        guard++;
      end while (phaseCnt != 2047 && guard < 2100);
      if (phaseCnt != 2047) checkOutput("alignTimeout", phaseCnt, 2047);
    end
    spd    = 12'd100;
    spdVld = 1'b1;
    @(posedge clk);
    #1 spdVld = 1'b0;
    checkOutput("tickCap.fwd", fwd, 0);
    checkOutput("tickCap.duty", duty, 0);
    checkOutput("tickCap.busy", busy, 1);
    checkTick("tickCapNext", 164, 1, 0);

    applyStimulus(-12'sd100);
    checkTick("rev2Zero", 0, 1, 0);
    checkTick("rev2Dead", 0, 0, 0);
    repeat (100) @(posedge clk);
    pulseReset();
    checkIdle("resetDead");
    checkTick("postReset1", 0, 0, 0);
    checkTick("postReset2", 0, 0, 0);
    checkOutput("postReset2.busy", busy, 0);

    applyStimulus(12'd1);
    checkTick("minMag", 65, 1, 0);
    applyStimulus(12'd1982);
    checkTick("belowSat", 2046, 1, 0);
    applyStimulus(12'd1983);
    checkTick("atSat", 2047, 1, 0);
    @(negedge clk);
    spd = 12'd1;
    checkTick("holdNoVld", 2047, 1, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
